// File: rtl/fc_pkg.sv
// Shared constants and state encoding for the MNIST fully-connected layers.
package fc_pkg;

  localparam int unsigned H1_DIM    = 32;
  localparam int unsigned N_CLASSES = 10;
  localparam int unsigned ACT_W     = 8;
  localparam int unsigned ACC_W     = 32;
  localparam int unsigned RD_LAT    = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BIAS,
    ST_MAC,
    ST_CMP,
    ST_DONE
  } state_t;

endpackage

// File: rtl/argmax_tracker.sv
// Running argmax: strict signed greater-than, so on ties the earliest (lowest) index is kept.
module argmax_tracker
  import fc_pkg::*;
#(
  parameter int unsigned IDX_W = 4,
  parameter int unsigned VAL_W = ACC_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    upd,
  input  logic [IDX_W-1:0]        idx,
  input  logic signed [VAL_W-1:0] val,
  output logic [IDX_W-1:0]        best_idx,
  output logic signed [VAL_W-1:0] best_val
);

  // clr marks the first candidate of a run, which is taken unconditionally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      best_idx <= '0;
      best_val <= '0;
    end else if (upd && (clr || (val > best_val))) begin
      best_idx <= idx;
      best_val <= val;
    end
  end

endmodule

// File: rtl/fc2_argmax_layer.sv
// Output FC layer: serial int8 MAC per class with bias, followed by running argmax.
// Optional macro FC2_LOGIT_OUT_EN exposes a per-logit write port for debug/softmax readout.
module fc2_argmax_layer
  import fc_pkg::*;
#(
  parameter int unsigned IN_DIM   = H1_DIM,
  parameter int unsigned OUT_DIM  = N_CLASSES,
  parameter int unsigned W_ADDR_W = $clog2(IN_DIM * OUT_DIM)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  output logic                         busy,
  output logic                         done,
  output logic [$clog2(IN_DIM)-1:0]    h_addr,
  input  logic signed [ACT_W-1:0]      h_data,
  output logic [W_ADDR_W-1:0]          w_addr,
  input  logic signed [ACT_W-1:0]      w_data,
  output logic [$clog2(OUT_DIM)-1:0]   b_addr,
  input  logic signed [ACC_W-1:0]      b_data,
  output logic [3:0]                   class_idx,
  output logic signed [ACC_W-1:0]      max_logit
`ifdef FC2_LOGIT_OUT_EN
  ,
  output logic                         logit_we,
  output logic [$clog2(OUT_DIM)-1:0]   logit_addr,
  output logic signed [ACC_W-1:0]      logit_data
`endif
);

  localparam int unsigned H_AW = $clog2(IN_DIM);
  localparam int unsigned B_AW = $clog2(OUT_DIM);

  state_t                   state;
  logic [B_AW-1:0]          j;
  logic [H_AW-1:0]          k;
  logic signed [ACC_W-1:0]  acc;
  logic signed [2*ACT_W-1:0] prod_c;
  logic signed [ACC_W-1:0]  prod_ext_c;
  logic                     cmp_c;

  assign prod_c     = h_data * w_data;
  assign prod_ext_c = ACC_W'(prod_c);
  assign cmp_c      = (state == ST_CMP);

  argmax_tracker #(.IDX_W(4), .VAL_W(ACC_W)) u_argmax (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (j == '0),
    .upd      (cmp_c),
    .idx      (4'(j)),
    .val      (acc),
    .best_idx (class_idx),
    .best_val (max_logit)
  );

  // Addresses are registered one cycle ahead so data lands in the cycle that consumes it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      j      <= '0;
      k      <= '0;
      acc    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      h_addr <= '0;
      w_addr <= '0;
      b_addr <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            j      <= '0;
            busy   <= 1'b1;
            b_addr <= '0;
            h_addr <= '0;
            w_addr <= '0;
            state  <= ST_BIAS;
          end
        end
        ST_BIAS: begin
          k      <= '0;
          h_addr <= H_AW'(RD_LAT);
          w_addr <= w_addr + W_ADDR_W'(RD_LAT);
          state  <= ST_MAC;
        end
        ST_MAC: begin
          if (k == '0) acc <= b_data + prod_ext_c;
          else         acc <= acc + prod_ext_c;
          if ((32'(k) + RD_LAT + 32'd1) < IN_DIM) begin
            h_addr <= h_addr + H_AW'(1);
            w_addr <= w_addr + W_ADDR_W'(1);
          end
          if (k == H_AW'(IN_DIM - 1)) state <= ST_CMP;
          else                        k     <= k + H_AW'(1);
        end
        ST_CMP: begin
          if (j == B_AW'(OUT_DIM - 1)) begin
            state <= ST_DONE;
          end else begin
            j      <= j + B_AW'(1);
            b_addr <= j + B_AW'(1);
            h_addr <= '0;
            w_addr <= W_ADDR_W'((32'(j) + 32'd1) * IN_DIM);
            state  <= ST_BIAS;
          end
        end
        ST_DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef FC2_LOGIT_OUT_EN
  // One write pulse per logit, aligned with the compare cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      logit_we   <= 1'b0;
      logit_addr <= '0;
      logit_data <= '0;
    end else begin
      logit_we <= 1'b0;
      if (cmp_c) begin
        logit_we   <= 1'b1;
        logit_addr <= j;
        logit_data <= acc;
      end
    end
  end
`endif

endmodule
